hilo_muldiv_ctrl: RTL and testbench

// Sequencer for the HI/LO register pair in the MIPS-lite core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 26 ++
 rtl/hilo_iter_core.sv | 70 +++++++
 rtl/hilo_muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operand width,
// op encodings (shared with the decoder) and FSM state encoding.
package hilo_muldiv_ctrl_pkg;

    localparam int HILO_LENGTH = 32;

    typedef enum logic [2:0] {
        HILO_OP_NONE  = 3'd0,
        HILO_OP_MULT  = 3'd1,
        HILO_OP_MULTU = 3'd2,
        HILO_OP_DIV   = 3'd3,
        HILO_OP_DIVU  = 3'd4,
        HILO_OP_MTHI  = 3'd5,
        HILO_OP_MTLO  = 3'd6,
        HILO_OP_RSVD  = 3'd7
    } hilo_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_WB   = 3'd4
    } hilo_state_e;

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative datapath: shift-add multiply (LSB first) or restoring divide (MSB first),
// one bit per step, plus the iteration counter. acc holds {upper, lower} halves.
module hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   load_lo,
    input  logic [WIDTH-1:0]   load_opd,
    output logic [2*WIDTH-1:0] acc,
    output logic               done
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] upper, lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_nxt;
    logic             ge;

    always_comb begin
        acc_d   = acc_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        upper   = acc_q[2*WIDTH-1:WIDTH];
        lower   = acc_q[WIDTH-1:0];
        sum     = {1'b0, upper} + ({1'b0, opd_q} & {(WIDTH+1){lower[0]}});
        shifted = {upper, lower[WIDTH-1]};
        ge      = (shifted >= {1'b0, opd_q});
        // When the trial subtract succeeds the true difference fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - opd_q;
        rem_nxt = ge ? diff : shifted[WIDTH-1:0];
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, load_lo};
            opd_d = load_opd;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_mode) begin
                acc_d = {rem_nxt, lower[WIDTH-2:0], ge};
            end else begin
                acc_d = {sum, lower[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            opd_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opd_q <= opd_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign done = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: captures MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the iterative core,
// sign-fixes the result and emits one-cycle HI/LO write strobes; stalls the pipe meanwhile.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = HILO_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    hilo_state_e      state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             wr_hi_q, wr_hi_d;
    logic             wr_lo_q, wr_lo_d;
    logic [WIDTH-1:0] hi_wdata_q, hi_wdata_d;
    logic [WIDTH-1:0] lo_wdata_q, lo_wdata_d;

    hilo_op_e         op_e;
    logic             is_mul_op, is_div_op, is_sgn_op;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    logic               core_load, core_step, core_done;
    logic [2*WIDTH-1:0] core_acc;

    assign op_e      = hilo_op_e'(op);
    assign is_mul_op = (op_e == HILO_OP_MULT) || (op_e == HILO_OP_MULTU);
    assign is_div_op = (op_e == HILO_OP_DIV)  || (op_e == HILO_OP_DIVU);
    assign is_sgn_op = (op_e == HILO_OP_MULT) || (op_e == HILO_OP_DIV);
    assign a_abs     = (is_sgn_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs     = (is_sgn_op && src_b[WIDTH-1]) ? -src_b : src_b;

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode (state_q == ST_DIV),
        .load_lo  (is_div_op ? a_abs : b_abs),
        .load_opd (is_div_op ? b_abs : a_abs),
        .acc      (core_acc),
        .done     (core_done)
    );

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_q) begin
            fix_lo = neg_q_q ? -core_acc[WIDTH-1:0]       : core_acc[WIDTH-1:0];
            fix_hi = neg_r_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
        end else begin
            {fix_hi, fix_lo} = neg_q_q ? -core_acc : core_acc;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        wr_hi_d    = wr_hi_q;
        wr_lo_d    = wr_lo_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        core_load = 1'b1;
                        state_d   = is_div_op ? ST_DIV : ST_MUL;
                        is_div_d  = is_div_op;
                        neg_q_d   = is_sgn_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r_d   = (op_e == HILO_OP_DIV) && src_a[WIDTH-1];
                        wr_hi_d   = 1'b1;
                        wr_lo_d   = 1'b1;
                    end else if (op_e == HILO_OP_MTHI) begin
                        hi_wdata_d = src_a;
                        wr_hi_d    = 1'b1;
                        wr_lo_d    = 1'b0;
                        state_d    = ST_WB;
                    end else if (op_e == HILO_OP_MTLO) begin
                        lo_wdata_d = src_a;
                        wr_hi_d    = 1'b0;
                        wr_lo_d    = 1'b1;
                        state_d    = ST_WB;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_done) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_wdata_d = fix_hi;
                    lo_wdata_d = fix_lo;
                    state_d    = ST_WB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            wr_hi_q    <= 1'b0;
            wr_lo_q    <= 1'b0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            wr_hi_q    <= wr_hi_d;
            wr_lo_q    <= wr_lo_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
        end
    end

    // WB is excluded from stall so the next EX op can read HI/LO right after the update.
    assign busy     = (state_q != ST_IDLE);
    assign stall    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX) ||
                      (start && (is_mul_op || is_div_op));
    assign hi_we    = (state_q == ST_WB) && wr_hi_q && !flush;
    assign lo_we    = (state_q == ST_WB) && wr_lo_q && !flush;
    assign hi_wdata = hi_wdata_q;
    assign lo_wdata = lo_wdata_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl against a plain-arithmetic HI/LO result model
// and latency/strobe expectations built per cycle.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        busy, stall, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_hi, mdl_lo;
    bit          hi_known, lo_known;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result {hi, lo} of a mul/div from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (o)
            3'd1: begin q = sa * sb; res = q; end
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) begin
                    res = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one op at cycle 0; abort_cyc>0 aborts in that cycle via flush (use_rst=0) or rst.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int abort_cyc, input bit use_rst);
        logic [39:0] stall_vec, busy_vec, exp_stall, exp_busy;
        int          hi_n, lo_n, hi_c, lo_c, end_c;
        logic [31:0] hi_d, lo_d;
        logic [63:0] res;
        bit          is_md, is_mt;
        stall_vec = '0; busy_vec = '0; exp_stall = '0; exp_busy = '0;
        hi_n = 0; lo_n = 0; hi_c = -1; lo_c = -1; hi_d = '0; lo_d = '0;
        is_md = (o >= 3'd1 && o <= 3'd4);
        is_mt = (o == 3'd5 || o == 3'd6);
        res   = model(o, a, b);

        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int c = 0; c < 40; c++) begin
            if (c == abort_cyc) begin
                if (use_rst) rst = 1'b1; else flush = 1'b1;
            end
            @(negedge clk);
            stall_vec[c] = stall;
            busy_vec[c]  = busy;
            if (hi_we) begin hi_n++; hi_c = c; hi_d = hi_wdata; end
            if (lo_we) begin lo_n++; lo_c = c; lo_d = lo_wdata; end
            @(posedge clk); #1;
            start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
            flush = 1'b0; rst = 1'b0;
        end

        if (is_md) begin
            end_c = (abort_cyc > 0 && abort_cyc < 34) ? abort_cyc : 34;
            exp_stall[0] = 1'b1;
            for (int c = 1; c <= end_c && c <= 33; c++) exp_stall[c] = 1'b1;
            for (int c = 1; c <= end_c; c++) exp_busy[c] = 1'b1;
        end else if (is_mt) begin
            exp_busy[1] = 1'b1;
        end
        chk("stall_trace", stall_vec, exp_stall);
        chk("busy_trace", busy_vec, exp_busy);

        if (is_md && abort_cyc <= 0) begin
            chk("hi_we_count", hi_n, 1);
            chk("lo_we_count", lo_n, 1);
            chk("hi_we_cycle", hi_c, 34);
            chk("lo_we_cycle", lo_c, 34);
            chk("hi_result", hi_d, res[63:32]);
            chk("lo_result", lo_d, res[31:0]);
            mdl_hi = res[63:32]; mdl_lo = res[31:0];
            hi_known = 1; lo_known = 1;
        end else if (is_mt) begin
            chk(o == 3'd5 ? "mthi_hi_count" : "mtlo_hi_count", hi_n, (o == 3'd5) ? 1 : 0);
            chk(o == 3'd5 ? "mthi_lo_count" : "mtlo_lo_count", lo_n, (o == 3'd6) ? 1 : 0);
            if (o == 3'd5) begin
                chk("mthi_cycle", hi_c, 1);
                chk("mthi_data", hi_d, a);
                mdl_hi = a; hi_known = 1;
            end else begin
                chk("mtlo_cycle", lo_c, 1);
                chk("mtlo_data", lo_d, a);
                mdl_lo = a; lo_known = 1;
            end
        end else begin
            chk("no_hi_strobe", hi_n, 0);
            chk("no_lo_strobe", lo_n, 0);
            if (is_md && use_rst) begin
                mdl_hi = '0; mdl_lo = '0; hi_known = 1; lo_known = 1;
            end else if (is_md) begin
                hi_known = 0; lo_known = 0;
            end
        end

        if (hi_known) chk("hi_wdata_hold", hi_wdata, mdl_hi);
        if (lo_known) chk("lo_wdata_hold", lo_wdata, mdl_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int          r_abort;
        bit          r_rst;

        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
        hi_known = 1; lo_known = 1; mdl_hi = '0; mdl_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hi_we", hi_we, 0);
        chk("rst_lo_we", lo_we, 0);
        chk("rst_hi_wdata", hi_wdata, 0);
        chk("rst_lo_wdata", lo_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1, 0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, -1, 0);
        do_op(3'd4, 32'd100, 32'd7, -1, 0);
        do_op(3'd4, 32'd5, 32'd0, -1, 0);
        do_op(3'd3, 32'hFFFF_FFFB, 32'd0, -1, 0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1, 0);
        do_op(3'd5, 32'h0000_1234, 32'd0, -1, 0);
        do_op(3'd6, 32'hCAFE_0001, 32'd0, -1, 0);
        do_op(3'd7, 32'h1111_1111, 32'd3, -1, 0);
        do_op(3'd4, 32'd1000, 32'd3, 10, 0);
        do_op(3'd2, 32'd12345, 32'd678, -1, 0);
        do_op(3'd1, 32'h0001_0000, 32'hFFFF_0000, 20, 1);
        do_op(3'd1, 32'hFFFF_FFFD, 32'd7, -1, 0);
        do_op(3'd3, 32'd9, 32'd3, 34, 0);
        do_op(3'd4, 32'hFFFF_FFFF, 32'd1, -1, 0);

        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_a = 32'h8000_0000;
                3: r_b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            r_abort = -1;
            r_rst   = 0;
            if (r_op >= 3'd1 && r_op <= 3'd4 && $urandom_range(0, 9) == 0) begin
                r_rst   = ($urandom_range(0, 1) == 1);
                r_abort = r_rst ? $urandom_range(1, 33) : $urandom_range(1, 34);
            end
            do_op(r_op, r_a, r_b, r_abort, r_rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
